// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch prediction table.
// The counter width is fixed here so every counter instance agrees on it.
package bp_pkg;

  localparam int CNT_W = 2;

  typedef logic [CNT_W-1:0] bp_cnt_t;

  localparam bp_cnt_t CNT_MAX = bp_cnt_t'((1 << CNT_W) - 1);
  localparam bp_cnt_t CNT_WNT = bp_cnt_t'((1 << (CNT_W - 1)) - 1);

  // One saturating step towards the resolved outcome; the end values are sticky.
  function automatic bp_cnt_t sat_step(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t nxt;
    if (taken) begin
      nxt = (cnt == CNT_MAX) ? cnt : cnt + bp_cnt_t'(1);
    end else begin
      nxt = (cnt == bp_cnt_t'(0)) ? cnt : cnt - bp_cnt_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_table_if.sv
// Fetch/resolve bus of the branch prediction table.
// master = pipeline side, slave = predictor.
interface branch_predictor_table_if #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int STAT_W = 16
);

  logic [PC_W-1:0]   pred_pc;
  logic              predict_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_mispredict;
  logic [STAT_W-1:0] mispred_cnt;

  modport master (
    output pred_pc, upd_valid, upd_idx, upd_taken,
    input  predict_taken, pred_idx, upd_mispredict, mispred_cnt
  );

  modport slave (
    input  pred_pc, upd_valid, upd_idx, upd_taken,
    output predict_taken, pred_idx, upd_mispredict, mispred_cnt
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Single saturating direction counter; resets to weakly-not-taken.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    we,
  input  logic    taken,
  output bp_cnt_t cnt
);

  bp_cnt_t cnt_d;
  bp_cnt_t cnt_q;

  // next counter value
  always_comb begin
    cnt_d = cnt_q;
    if (we) begin
      cnt_d = sat_step(cnt_q, taken);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor_table.sv
// PC-indexed table of saturating counters with zero-latency prediction.
// Define BP_GSHARE_EN to fold a non-speculative global history into the index.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_predictor_table_if.slave  bus
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [IDX_W-1:0]  base_s;
  logic [IDX_W-1:0]  idx_s;
  bp_cnt_t           cnt_s [ENTRIES];
  logic              mispredict_s;
  logic              upd_mispredict_d;
  logic              upd_mispredict_q;
  logic [STAT_W-1:0] mispred_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q;
  logic              unused_pc_s;

  assign base_s      = bus.pred_pc[IDX_W+1:2];
  assign unused_pc_s = ^{bus.pred_pc[PC_W-1:IDX_W+2], bus.pred_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_d;
  logic [HIST_W-1:0] ghr_q;

  assign idx_s = base_s ^ IDX_W'(ghr_q);

  // history only advances on resolved branches
  always_comb begin
    ghr_d = ghr_q;
    if (bus.upd_valid) begin
      ghr_d = {ghr_q[HIST_W-2:0], bus.upd_taken};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // global history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign idx_s = base_s;
`endif

  // The read sees the pre-update table, so a same-index write shows up next cycle.
  assign bus.pred_idx      = idx_s;
  assign bus.predict_taken = cnt_s[idx_s][CNT_W-1];

  assign mispredict_s = bus.upd_valid && (cnt_s[bus.upd_idx][CNT_W-1] != bus.upd_taken);

  // mispredict flag and saturating statistics
  always_comb begin
    upd_mispredict_d = mispredict_s;
    mispred_cnt_d    = mispred_cnt_q;
    if (mispredict_s && (mispred_cnt_q != {STAT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end else begin
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // registered update outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_mispredict_q <= 1'b0;
      mispred_cnt_q    <= '0;
    end else begin
      upd_mispredict_q <= upd_mispredict_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign bus.upd_mispredict = upd_mispredict_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    bp_sat_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus.upd_valid && (bus.upd_idx == IDX_W'(i))),
      .taken (bus.upd_taken),
      .cnt   (cnt_s[i])
    );
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed scoreboard bench for branch_predictor_table (16 entries, 2-bit counters, 4-bit stats).
// Gshare checks are included when BP_GSHARE_EN is defined.
module tb_branch_predictor_table;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_table_if #(.PC_W(32), .IDX_W(4), .STAT_W(4)) bus ();

  branch_predictor_table #(.PC_W(32), .IDX_W(4), .HIST_W(4), .STAT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_cnt[16];
  int          m_stat;
  logic [3:0]  m_ghr;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 1;
    m_stat = 0;
    m_ghr  = 4'd0;
  endtask

  // drive a PC that lands on table index idx and check the combinational read
  task automatic predict(input logic [3:0] idx, input string tag);
    logic [3:0] base;
    base = idx ^ m_ghr;
    bus.pred_pc = {26'd0, base, 2'b00};
    #1;
    push_exp({tag, "_idx"}, {28'd0, idx});
    push_exp({tag, "_taken"}, {31'd0, (m_cnt[idx] >= 2)});
    check_next({28'd0, bus.pred_idx});
    check_next({31'd0, bus.predict_taken});
  endtask

  task automatic model_update(input logic [3:0] idx, input logic taken, input string tag);
    logic mis;
    mis = ((m_cnt[idx] >= 2) != taken);
    if (taken) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
    else       m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
    if (mis) m_stat = (m_stat == 15) ? 15 : m_stat + 1;
`ifdef BP_GSHARE_EN
    m_ghr = {m_ghr[2:0], taken};
`endif
    push_exp({tag, "_mis"}, {31'd0, mis});
    push_exp({tag, "_cnt"}, m_stat);
  endtask

  task automatic update(input logic [3:0] idx, input logic taken, input string tag);
    @(negedge clk);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = idx;
    bus.upd_taken = taken;
    model_update(idx, taken, tag);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    check_next({31'd0, bus.upd_mispredict});
    check_next({28'd0, bus.mispred_cnt});
  endtask

  task automatic async_reset_pulse(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_exp({tag, "_cnt"}, 32'd0);
    push_exp({tag, "_mis"}, 32'd0);
    check_next({28'd0, bus.mispred_cnt});
    check_next({31'd0, bus.upd_mispredict});
    predict(4'd5, {tag, "_p5"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.pred_pc   = 32'd0;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = 4'd0;
    bus.upd_taken = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) predict(4'(i), "reset_pred");
    push_exp("reset_cnt", 32'd0);
    check_next({28'd0, bus.mispred_cnt});

    update(4'd5, 1'b1, "up1");
    predict(4'd5, "up1_pred");
    update(4'd5, 1'b1, "up2");
    update(4'd5, 1'b1, "up3");
    update(4'd5, 1'b1, "up4_sat");
    update(4'd5, 1'b0, "up_nt1");
    predict(4'd5, "up_nt1_pred");
    update(4'd5, 1'b0, "up_nt2");
    predict(4'd5, "up_nt2_pred");

    for (int i = 0; i < 3; i++) update(4'd2, 1'b0, "dn");
    predict(4'd2, "dn_pred");
    update(4'd2, 1'b1, "dn_t1");
    predict(4'd2, "dn_t1_pred");
    update(4'd2, 1'b1, "dn_t2");
    predict(4'd2, "dn_t2_pred");

    // idle cycle: flag drops, statistics hold
    @(posedge clk);
    #1;
    push_exp("idle_mis", 32'd0);
    push_exp("idle_cnt", m_stat);
    check_next({31'd0, bus.upd_mispredict});
    check_next({28'd0, bus.mispred_cnt});

    // same-cycle read and write of index 3
    @(negedge clk);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 4'd3;
    bus.upd_taken = 1'b1;
    predict(4'd3, "coll_old");
    model_update(4'd3, 1'b1, "coll");
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    check_next({31'd0, bus.upd_mispredict});
    check_next({28'd0, bus.mispred_cnt});
    predict(4'd3, "coll_new");

    async_reset_pulse("arst");
    predict(4'd3, "arst_p3");

    for (int i = 0; i < 18; i++) update(4'd7, 1'(i % 2 == 0), "alt");

`ifdef BP_GSHARE_EN
    async_reset_pulse("g_rst");
    update(4'd0, 1'b1, "g1");
    update(4'd0, 1'b1, "g2");
    update(4'd0, 1'b0, "g3");
    update(4'd0, 1'b1, "g4");
    @(negedge clk);
    bus.pred_pc = 32'h0000_0010;
    #1;
    push_exp("g_idx", 32'h9);
    check_next({28'd0, bus.pred_idx});
    rst_n = 1'b0;
    #1;
    push_exp("g_rst_idx", 32'h4);
    push_exp("g_rst_taken", 32'h0);
    check_next({28'd0, bus.pred_idx});
    check_next({31'd0, bus.predict_taken});
    rst_n = 1'b1;
    model_reset();
    predict(4'd0, "g_rst_p0");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
